mem_arbiter: RTL and testbench

Single-ported RAM arbiter between the instruction-fetch port and the data port of the pipelined datapath. It sits between the datapath/cache side (`imemREN`/`dmemREN`/`dmemWEN` requests) and one variable-latency RAM port. It grants one requester at a time and holds the grant until the RAM completes. Data requests have priority. A streak counter guarantees instruction fetch is never starved.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants a single variable-latency RAM port to either the
// instruction-fetch requester or the data requester, one transaction at a
// time. Data has priority; a streak counter forces an instruction grant after
// MAX_DSTREAK consecutive data completions while a fetch is waiting.
module mem_arbiter #(
   parameter int MAX_DSTREAK = 4,
   parameter int CW          = $clog2(MAX_DSTREAK + 1)
) (
   input  logic        CLK,
   input  logic        nRST,
   // instruction side
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   // data side
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   // RAM side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   localparam logic [1:0]    RAM_FREE   = 2'd0;
   localparam logic [1:0]    RAM_BUSY   = 2'd1;
   localparam logic [1:0]    RAM_ACCESS = 2'd2;
   localparam logic [1:0]    RAM_ERROR  = 2'd3;
   localparam logic [CW-1:0] DMAX       = CW'(MAX_DSTREAK);

   typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

   state_t        state, next_state;
   logic [CW-1:0] dstreak, next_dstreak;
   logic [31:0]   lat_addr, lat_store;
   logic          lat_wr;
   logic          done, fail;

   // increment that sticks at the streak limit
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v >= DMAX) ? DMAX : v + 1'b1;
   endfunction

   assign done = (ramstate == RAM_ACCESS);
   assign fail = (ramstate == RAM_ERROR);

   // next-state and streak-counter update
   always_comb begin
      next_state   = state;
      next_dstreak = dstreak;
      unique case (state)
         IDLE: begin
            if ((dREN || dWEN) && !(iREN && dstreak == DMAX))
               next_state = DGNT;
            else if (iREN)
               next_state = IGNT;
         end
         IGNT: begin
            if (done) begin
               next_state   = IDLE;
               next_dstreak = '0;
            end else if (fail) begin
               next_state = IDLE;
            end
         end
         DGNT: begin
            if (done) begin
               next_state   = IDLE;
               next_dstreak = iREN ? sat_inc(dstreak) : '0;
            end else if (fail) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // state, streak, sticky error and the owner's latched request
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state     <= IDLE;
         dstreak   <= '0;
         err       <= 1'b0;
         lat_addr  <= '0;
         lat_store <= '0;
         lat_wr    <= 1'b0;
      end else begin
         state   <= next_state;
         dstreak <= next_dstreak;
         if (state != IDLE && fail)
            err <= 1'b1;
         if (state == IDLE && next_state == DGNT) begin
            lat_addr  <= daddr;
            lat_store <= dstore;
            lat_wr    <= dWEN;
         end else if (state == IDLE && next_state == IGNT) begin
            lat_addr  <= iaddr;
            lat_store <= dstore;
            lat_wr    <= 1'b0;
         end
      end
   end

   // RAM drive and per-requester completion signals
   always_comb begin
      ramREN   = (state == IGNT) || (state == DGNT && !lat_wr);
      ramWEN   = (state == DGNT) && lat_wr;
      ramaddr  = lat_addr;
      ramstore = lat_store;
      iwait    = !(state == IGNT && done);
      dwait    = !(state == DGNT && done);
      iload    = (state == IGNT && done) ? ramload : '0;
      dload    = (state == DGNT && done && !lat_wr) ? ramload : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with the RAM status driven
// cycle by cycle from the bench.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN, err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   int nvec = 0;
   int nbad = 0;

   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   mem_arbiter #(.MAX_DSTREAK(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, " ramREN"}, 32'(ramREN), 0);
      chk({tag, " ramWEN"}, 32'(ramWEN), 0);
      chk({tag, " ramaddr"}, ramaddr, 0);
      chk({tag, " ramstore"}, ramstore, 0);
      chk({tag, " iwait"}, 32'(iwait), 1);
      chk({tag, " dwait"}, 32'(dwait), 1);
      chk({tag, " iload"}, iload, 0);
      chk({tag, " dload"}, dload, 0);
      chk({tag, " err"}, 32'(err), 0);
   endtask

   initial begin
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
      step(); step();
      #1;
      reset_vals("rst");
      nRST = 1'b1;

      // single instruction fetch, 2 BUSY cycles
      iREN = 1; iaddr = 32'h40; #1;
      chk("if c0 ramREN", 32'(ramREN), 0);
      step(); ramstate = BUSY; #1;
      chk("if c1 ramREN", 32'(ramREN), 1);
      chk("if c1 ramaddr", ramaddr, 32'h40);
      chk("if c1 iwait", 32'(iwait), 1);
      step(); #1;
      chk("if c2 ramREN", 32'(ramREN), 1);
      chk("if c2 iwait", 32'(iwait), 1);
      step(); ramstate = ACCESS; ramload = 32'h8C010004; iREN = 0; #1;
      chk("if c3 ramREN", 32'(ramREN), 1);
      chk("if c3 iwait", 32'(iwait), 0);
      chk("if c3 iload", iload, 32'h8C010004);
      chk("if c3 dwait", 32'(dwait), 1);
      step(); ramstate = FREE; #1;
      chk("if c4 ramREN", 32'(ramREN), 0);
      chk("if c4 iwait", 32'(iwait), 1);
      chk("if c4 iload", iload, 0);

      // simultaneous instruction and data write: data first
      iREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; #1;
      step(); ramstate = ACCESS; ramload = 32'hFFFF0000; #1;
      chk("sim ramWEN", 32'(ramWEN), 1);
      chk("sim ramREN", 32'(ramREN), 0);
      chk("sim ramaddr", ramaddr, 32'h100);
      chk("sim ramstore", ramstore, 32'hDEADBEEF);
      chk("sim dwait", 32'(dwait), 0);
      chk("sim iwait", 32'(iwait), 1);
      chk("sim dload", dload, 0);
      dWEN = 0;
      step(); ramstate = FREE; #1;
      chk("sim idle ramREN", 32'(ramREN), 0);
      chk("sim idle ramWEN", 32'(ramWEN), 0);
      chk("sim idle iwait", 32'(iwait), 1);
      chk("sim streak", 32'(dut.dstreak), 1);
      step(); ramstate = ACCESS; ramload = 32'h1234; #1;
      chk("sim ig ramREN", 32'(ramREN), 1);
      chk("sim ig ramaddr", ramaddr, 32'h40);
      chk("sim ig iwait", 32'(iwait), 0);
      chk("sim ig iload", iload, 32'h1234);
      iREN = 0;
      step(); ramstate = FREE; #1;
      chk("sim end streak", 32'(dut.dstreak), 0);

      // starvation guard: D D D D I D
      dREN = 1; iREN = 1; daddr = 32'h200; iaddr = 32'h80;
      for (int k = 0; k < 6; k++) begin
         logic isi;
         logic [31:0] sexp;
         isi  = (k == 4);
         sexp = (k < 4) ? 32'(k + 1) : (k == 4) ? 32'd0 : 32'd1;
         step(); ramstate = ACCESS; ramload = 32'(k + 8'hA0); #1;
         chk($sformatf("stv%0d dwait", k), 32'(dwait), isi ? 1 : 0);
         chk($sformatf("stv%0d iwait", k), 32'(iwait), isi ? 0 : 1);
         chk($sformatf("stv%0d ramaddr", k), ramaddr, isi ? 32'h80 : 32'h200);
         chk($sformatf("stv%0d dload", k), dload, isi ? 0 : 32'(k + 8'hA0));
         step(); ramstate = FREE; #1;
         chk($sformatf("stv%0d streak", k), 32'(dut.dstreak), sexp);
      end
      dREN = 0; iREN = 0;

      // request withdrawn mid-grant; dREN+dWEN resolves to write
      dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h55; #1;
      step(); ramstate = BUSY; dREN = 0; dWEN = 0; #1;
      chk("wd b1 ramWEN", 32'(ramWEN), 1);
      chk("wd b1 ramREN", 32'(ramREN), 0);
      chk("wd b1 dwait", 32'(dwait), 1);
      step(); #1;
      chk("wd b2 ramWEN", 32'(ramWEN), 1);
      chk("wd b2 dwait", 32'(dwait), 1);
      step(); ramstate = ACCESS; #1;
      chk("wd acc dwait", 32'(dwait), 0);
      chk("wd acc ramstore", ramstore, 32'h55);
      step(); ramstate = FREE; #1;
      chk("wd idle ramWEN", 32'(ramWEN), 0);
      chk("wd idle dwait", 32'(dwait), 1);
      step(); #1;
      chk("wd idle2 ramWEN", 32'(ramWEN), 0);
      chk("wd idle2 ramREN", 32'(ramREN), 0);

      // RAM error during IGNT, then retry
      iREN = 1; iaddr = 32'h44; #1;
      step(); ramstate = ERROR; #1;
      chk("er iwait", 32'(iwait), 1);
      chk("er err pre", 32'(err), 0);
      step(); ramstate = FREE; #1;
      chk("er err set", 32'(err), 1);
      chk("er idle ramREN", 32'(ramREN), 0);
      step(); ramstate = ACCESS; ramload = 32'h77; #1;
      chk("er retry ramREN", 32'(ramREN), 1);
      chk("er retry iwait", 32'(iwait), 0);
      chk("er retry iload", iload, 32'h77);
      iREN = 0;
      step(); ramstate = FREE; #1;
      chk("er sticky", 32'(err), 1);

      // reset mid-transaction
      dREN = 1; daddr = 32'h400; #1;
      step(); ramstate = BUSY; #1;
      chk("rs dg ramREN", 32'(ramREN), 1);
      chk("rs dg ramaddr", ramaddr, 32'h400);
      nRST = 0; #2; nRST = 1; #1;
      chk("rs glitch ramREN", 32'(ramREN), 1);
      step(); #1;
      chk("rs held ramREN", 32'(ramREN), 1);
      chk("rs held err", 32'(err), 1);
      nRST = 0; dREN = 0;
      step(); #1;
      reset_vals("rs mid");
      nRST = 1; ramstate = FREE;
      step(); #1;
      chk("rs after ramREN", 32'(ramREN), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
